// File: rtl/bus_arbiter.sv
// Eight-requester round-robin bus arbiter with bounded bursts and a LOCK override.
// GNT, S and BUSY are driven straight from registers.
module bus_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       CLK,
    input  logic       RES_N,
    input  logic [7:0] REQ,
    input  logic       LOCK,
    output logic [7:0] GNT,
    output logic [2:0] S,
    output logic       BUSY
);
    localparam logic [3:0] BC_MAX = 4'(MAX_BURST);

    typedef enum logic {IDLE, OWN} state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [3:0] bc;
    logic [2:0] base;
    logic [2:0] winner;
    logic       found;
    logic       release_now;

    assign release_now = (state == OWN) && (!REQ[S] || ((bc == BC_MAX) && !LOCK));

    // A releasing owner starts the search one past itself, so it is picked last.
    assign base  = release_now ? (S + 3'd1) : ptr;
    assign found = |REQ;

    // Scan from the far end so the nearest requester to base overwrites the others.
    always_comb begin
        winner = base;
        for (int i = 7; i >= 0; i--) begin
            if (REQ[base + 3'(i)]) winner = base + 3'(i);
        end
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state <= IDLE;
            GNT   <= '0;
            S     <= '0;
            BUSY  <= 1'b0;
            ptr   <= '0;
            bc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= OWN;
                        GNT   <= 8'd1 << winner;
                        S     <= winner;
                        BUSY  <= 1'b1;
                        bc    <= 4'd1;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        ptr <= S + 3'd1;
                        if (found) begin
                            GNT <= 8'd1 << winner;
                            S   <= winner;
                            bc  <= 4'd1;
                        end else begin
                            state <= IDLE;
                            GNT   <= '0;
                            BUSY  <= 1'b0;
                            bc    <= '0;
                        end
                    end else if (bc != BC_MAX) begin
                        bc <= bc + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations plus a long
// randomized run, every cycle compared against a search-order reference model.
module tb_bus_arbiter;
    localparam int MB = 4;

    logic       CLK   = 1'b0;
    logic       RES_N = 1'b0;
    logic       LOCK  = 1'b0;
    logic [7:0] REQ   = 8'h00;
    logic [7:0] GNT;
    logic [2:0] S;
    logic       BUSY;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: who owns the bus, how many beats so far, where the search starts.
    bit m_busy;
    int m_s;
    int m_ptr;
    int m_bc;

    bus_arbiter #(.MAX_BURST(MB)) dut (
        .CLK  (CLK),
        .RES_N(RES_N),
        .REQ  (REQ),
        .LOCK (LOCK),
        .GNT  (GNT),
        .S    (S),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic int pick(logic [7:0] req, int ptr);
        for (int k = 0; k < 8; k++) begin
            if (req[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_s    = 0;
        m_ptr  = 0;
        m_bc   = 0;
    endtask

    task automatic model_step();
        logic [7:0] r;
        r = REQ;
        if (!RES_N) begin
            model_reset();
        end else if (!m_busy) begin
            if (r != 0) begin
                m_s    = pick(r, m_ptr);
                m_busy = 1'b1;
                m_bc   = 1;
            end
        end else if (r[m_s] == 1'b0 || (m_bc == MB && !LOCK)) begin
            m_ptr = (m_s + 1) % 8;
            if (r != 0) begin
                m_s  = pick(r, m_ptr);
                m_bc = 1;
            end else begin
                m_busy = 1'b0;
                m_bc   = 0;
            end
        end else if (m_bc < MB) begin
            m_bc++;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("gnt_model",  32'(GNT),  m_busy ? (32'd1 << m_s) : 32'd0);
        check("s_model",    32'(S),    32'(m_s));
        check("busy_model", 32'(BUSY), 32'(m_busy));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic tick_exp(string name, logic [7:0] exp_gnt);
        tick();
        check(name, 32'(GNT), 32'(exp_gnt));
    endtask

    // Reset must clear outputs without waiting for a clock edge.
    task automatic do_reset();
        RES_N = 1'b0;
        #1;
        check("rst_gnt",  32'(GNT),  32'h0);
        check("rst_s",    32'(S),    32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        model_reset();
        REQ  = 8'h00;
        LOCK = 1'b0;
        tick();
        RES_N = 1'b1;
    endtask

    initial begin
        model_reset();

        // Single requester holds the bus across burst expiry.
        do_reset();
        REQ = 8'h01;
        tick();
        check("first_gnt",  32'(GNT),  32'h01);
        check("first_s",    32'(S),    32'h0);
        check("first_busy", 32'(BUSY), 32'h1);
        repeat (8) tick_exp("solo_hold", 8'h01);

        // Two requesters alternate every MAX_BURST beats with pointer wrap.
        do_reset();
        REQ = 8'h81;
        for (int k = 0; k < 9; k++)
            tick_exp("rr_0x81", (k < 4) ? 8'h01 : (k < 8) ? 8'h80 : 8'h01);

        // Owner drops its request early: immediate handover.
        do_reset();
        REQ = 8'h0C;
        tick_exp("drop_b1", 8'h04);
        tick_exp("drop_b2", 8'h04);
        REQ = 8'h08;
        tick();
        check("drop_gnt", 32'(GNT), 32'h08);
        check("drop_s",   32'(S),   32'h3);

        // LOCK extends tenure past the burst limit.
        do_reset();
        REQ = 8'h03;
        tick_exp("lock_b1", 8'h01);
        tick_exp("lock_b2", 8'h01);
        LOCK = 1'b1;
        repeat (5) tick_exp("lock_hold", 8'h01);
        LOCK = 1'b0;
        tick_exp("lock_rel", 8'h02);

        // Release to idle keeps S; next search starts past old owner and wraps.
        do_reset();
        REQ = 8'h20;
        tick_exp("own5", 8'h20);
        REQ = 8'h00;
        tick();
        check("idle_gnt",  32'(GNT),  32'h0);
        check("idle_busy", 32'(BUSY), 32'h0);
        check("idle_s",    32'(S),    32'h5);
        REQ = 8'h21;
        tick_exp("wrap_gnt", 8'h01);

        // Reset mid-burst, then restart from pointer 0.
        do_reset();
        REQ = 8'h10;
        tick_exp("own4_b1", 8'h10);
        tick_exp("own4_b2", 8'h10);
        do_reset();
        REQ = 8'h30;
        tick_exp("post_rst", 8'h10);

        // Randomized traffic; requests tend to persist so bursts and LOCK matter.
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) do_reset();
            if ($urandom_range(0, 9) < 3) begin
                if ($urandom_range(0, 4) == 0) REQ = 8'h00;
                else REQ = 8'($urandom) & 8'($urandom | $urandom);
            end
            LOCK = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum consecutive beats a grantee holds the bus while others wait; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RES_N  input  1  reset, asynchronous, active-low.
REQ-004 REQ  input  8  per-requester bus request; bit i = requester i, level-sensitive.
REQ-005 LOCK  input  1  current grantee extends its tenure beyond MAX_BURST while high.
REQ-006 GNT  output  8  registered one-hot grant; all-zero when bus is idle.
REQ-007 S  output  3  registered binary index of the grantee; drives the select of the 8-input, 8-bit bus mux.
REQ-008 BUSY  output  1  registered; high exactly when GNT is non-zero.

Function
REQ-009 Two states: IDLE (no grantee) and OWN (one grantee); GNT, S and BUSY are decoded from registered state only, with no combinational path from REQ or LOCK.
REQ-010 Round-robin pointer PTR (3 bits): winner = first i with REQ[i]=1 in search order PTR, PTR+1, ..., PTR+7, mod 8.
REQ-011 IDLE, REQ=0: remain IDLE; GNT=0, BUSY=0, S holds its last value.
REQ-012 IDLE, REQ!=0: next cycle enter OWN; GNT=one-hot(winner), S=winner, BUSY=1, beat counter BC=1; latency REQ->GNT is exactly one cycle.
REQ-013 OWN: each cycle with GNT high counts as one beat; BC increments per cycle, saturating at MAX_BURST.
REQ-014 OWN release condition: REQ[S]=0, or (BC==MAX_BURST and LOCK=0).
REQ-015 On release, PTR <= S+1 mod 8 (3-bit wrap, 7->0), and the winner is searched from the updated PTR in the same cycle.
REQ-016 On release with a winner: direct handover, no idle cycle; next cycle GNT=one-hot(new winner), S=new winner, BC=1.
REQ-017 On release with no winner: next cycle IDLE, GNT=0, BUSY=0.
REQ-018 Burst expiry with the owner still requesting and no other requester: owner re-granted (searched last); GNT stays continuously high, BC restarts at 1.
REQ-019 LOCK high at BC==MAX_BURST: no release; BC remains MAX_BURST; release occurs in the first cycle LOCK=0 or REQ[S]=0.
REQ-020 LOCK is ignored in IDLE and whenever REQ[S]=0; a dropped request always releases.
REQ-021 PTR changes only on release; a grant from IDLE does not modify PTR.
REQ-022 GNT is always zero or one-hot; S equals the index of the set GNT bit whenever BUSY=1.
REQ-023 MAX_BURST=1: every beat is a release point; with two or more requesters, grants rotate every cycle.

Reset
REQ-024 RES_N low immediately forces state IDLE, GNT=0, S=0, BUSY=0, PTR=0, BC=0, independent of CLK.
REQ-025 Reset asserted mid-tenure drops the grant immediately; after RES_N rises, arbitration restarts from PTR=0 on the first rising edge with REQ!=0.

Verification
REQ-026 Reset, then REQ=0x01 held: next edge GNT=0x01, S=0, BUSY=1; with MAX_BURST=4 and no other requester, GNT stays 0x01 continuously.
REQ-027 MAX_BURST=4, REQ=0x81 held from reset: GNT=0x01 for 4 cycles, then 0x80 for 4, then 0x01 (PTR wraps 7->0); no idle cycle between grants.
REQ-028 Owner 2 with REQ=0x0C, drop REQ[2] at beat 2: next edge GNT=0x08, S=3, BC=1.
REQ-029 MAX_BURST=4, REQ=0x03, LOCK=1 from beat 3: GNT=0x01 for 7 cycles; LOCK dropped after beat 7 -> next edge GNT=0x02.
REQ-030 Owner 5 granted, REQ drops to 0: next edge GNT=0, BUSY=0, S=5; then REQ=0x21 -> GNT=0x01 (search from PTR=6 wraps to 0).
REQ-031 RES_N pulsed low mid-burst (owner 4): GNT=0 and S=0 without a clock edge; after release with REQ=0x30, first grant is 0x10.
